// File: rtl/sram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter_if
//   Bundle of every signal between the CPU instruction/data ports, the
//   arbiter and the shared single-port SRAM.
//
//   Instruction port : i_req, i_addr -> i_gnt, i_rvalid, i_rdata
//   Data port        : d_req, d_wen, d_addr, d_wdata -> d_gnt, d_rvalid, d_rdata
//   RAM side         : ram_en, ram_wen, ram_addr, ram_wdata <- ram_rdata
//
//   Modports:
//     slave  - the arbiter's view (accepts requests, drives the RAM)
//     master - the environment's view (CPU ports plus the RAM model)
// ---------------------------------------------------------------------------
interface sram_port_arbiter_if #(
    parameter int RAM_AW = 16,
    parameter int DATA_W = 32
);
    // instruction port
    logic              i_req;
    logic [31:0]       i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    // data port
    logic              d_req;
    logic [3:0]        d_wen;
    logic [31:0]       d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    // RAM side
    logic              ram_en;
    logic [3:0]        ram_wen;
    logic [RAM_AW-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_wen, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output ram_en, ram_wen, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_wen, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  ram_en, ram_wen, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter
//   Shares one single-port synchronous SRAM (1-cycle read latency) between
//   the CPU instruction port and the CPU data port. One requester is granted
//   per cycle (combinationally), read data returns the cycle after the grant.
//
//   Ports:
//     clk  - clock, RAM samples on posedge
//     rst  - asynchronous reset, active-high
//     bus  - sram_port_arbiter_if.slave (instruction port, data port, RAM)
//
//   Configuration macro ARB_RR_EN:
//     defined   - on contention the sides strictly alternate via rr_ptr
//                 (0 = inst next, 1 = data next)
//     undefined - data has priority; after STARVE_MAX consecutive inst
//                 denials the instruction port is forced to win once
// ---------------------------------------------------------------------------
module sram_port_arbiter #(
    parameter int RAM_AW     = 16,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_port_arbiter_if.slave    bus
);

    logic i_gnt_c;
    logic d_gnt_c;
    logic contended;

    assign contended = bus.i_req && bus.d_req;

`ifdef ARB_RR_EN
    // -----------------------------------------------------------------------
    // Round-robin: pointer flips after every contended grant so the other
    // side gets the next contended cycle.
    // -----------------------------------------------------------------------
    logic rr_ptr_reg;
    logic rr_ptr_next;

    always_comb begin
        i_gnt_c     = 1'b0;
        d_gnt_c     = 1'b0;
        rr_ptr_next = rr_ptr_reg;
        if (!rst) begin
            if (contended) begin
                i_gnt_c     = ~rr_ptr_reg;
                d_gnt_c     = rr_ptr_reg;
                rr_ptr_next = ~rr_ptr_reg;
            end else begin
                i_gnt_c = bus.i_req;
                d_gnt_c = bus.d_req;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg <= 1'b0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end
`else
    // -----------------------------------------------------------------------
    // Fixed data priority with starvation guard. The counter tracks
    // consecutive cycles in which inst was requesting but lost.
    // -----------------------------------------------------------------------
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt_reg;
    logic [CNT_W-1:0] starve_cnt_next;
    logic             inst_forced;

    assign inst_forced = (starve_cnt_reg == CNT_MAX);

    always_comb begin
        i_gnt_c = 1'b0;
        d_gnt_c = 1'b0;
        if (!rst) begin
            i_gnt_c = bus.i_req && (!bus.d_req || inst_forced);
            d_gnt_c = bus.d_req && !i_gnt_c;
        end
    end

    always_comb begin
        starve_cnt_next = '0;
        if (bus.i_req && !i_gnt_c) begin
            starve_cnt_next = inst_forced ? starve_cnt_reg : starve_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_reg <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    // contention is only meaningful for the round-robin pointer
    logic unused_contended;
    assign unused_contended = contended;
`endif

    // -----------------------------------------------------------------------
    // RAM request mux: the winner's word address / write data go to the RAM.
    // -----------------------------------------------------------------------
    assign bus.i_gnt     = i_gnt_c;
    assign bus.d_gnt     = d_gnt_c;
    assign bus.ram_en    = i_gnt_c || d_gnt_c;
    assign bus.ram_wen   = d_gnt_c ? bus.d_wen : 4'h0;
    assign bus.ram_addr  = d_gnt_c ? bus.d_addr[RAM_AW+1:2] : bus.i_addr[RAM_AW+1:2];
    assign bus.ram_wdata = d_gnt_c ? bus.d_wdata : '0;

    // byte-offset bits and bits above the RAM window are intentionally dropped
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.i_addr[1:0], bus.i_addr[31:RAM_AW+2],
                                bus.d_addr[1:0], bus.d_addr[31:RAM_AW+2]};

    // -----------------------------------------------------------------------
    // Return pipeline: valid one cycle after a read grant (writes give none).
    // Async reset drops anything in flight.
    // -----------------------------------------------------------------------
    logic i_rvalid_reg;
    logic d_rvalid_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_rvalid_reg <= 1'b0;
            d_rvalid_reg <= 1'b0;
        end else begin
            i_rvalid_reg <= i_gnt_c;
            d_rvalid_reg <= d_gnt_c && (bus.d_wen == 4'h0);
        end
    end

    assign bus.i_rvalid = i_rvalid_reg;
    assign bus.d_rvalid = d_rvalid_reg;
    assign bus.i_rdata  = i_rvalid_reg ? bus.ram_rdata : '0;
    assign bus.d_rdata  = d_rvalid_reg ? bus.ram_rdata : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_port_arbiter
//   Directed steps followed by random traffic against a reference model of
//   the arbitration rules and a shadow copy of memory contents.
// ---------------------------------------------------------------------------
module tb_sram_port_arbiter;
    localparam int RAM_AW     = 16;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_port_arbiter_if #(.RAM_AW(RAM_AW), .DATA_W(DATA_W)) bus ();

    sram_port_arbiter #(
        .RAM_AW    (RAM_AW),
        .DATA_W    (DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // behavioural single-port RAM, 1-cycle read latency
    logic [31:0] mem     [0:65535];
    logic [31:0] ref_mem [0:65535];

    always @(posedge clk) begin
        if (bus.ram_en) begin
            for (int b = 0; b < 4; b++)
                if (bus.ram_wen[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
            bus.ram_rdata <= mem[bus.ram_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    // reference arbitration state
    int ref_denials;
    bit ref_inst_next;

    // observations from the last cycle
    bit          obs_i_gnt, obs_d_gnt, obs_d_rvalid;
    logic [31:0] obs_ram_addr, obs_i_rdata, obs_d_rdata;

    function automatic logic [31:0] init_val(int k);
        return (k * 32'h01010101) ^ 32'hA5A5_0000;
    endfunction

    function automatic int widx(logic [31:0] a);
        return int'(a[RAM_AW+1:2]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ref_denials   = 0;
        ref_inst_next = 1'b1;
    endtask

    // One clock of traffic. Entered just after a posedge; leaves just after
    // the next posedge with the return path checked.
    task automatic do_cycle(input bit ir, input logic [31:0] ia,
                            input bit dr, input logic [3:0] dw,
                            input logic [31:0] da, input logic [31:0] dd);
        bit e_i, e_d, e_iv, e_dv;
        logic [31:0] e_ir, e_dr, wv;
        bus.i_req   = ir;
        bus.i_addr  = ia;
        bus.d_req   = dr;
        bus.d_wen   = dw;
        bus.d_addr  = da;
        bus.d_wdata = dd;
`ifdef ARB_RR_EN
        e_i = ir && (!dr || ref_inst_next);
`else
        e_i = ir && (!dr || ref_denials >= STARVE_MAX);
`endif
        e_d = dr && !e_i;

        @(negedge clk);
        obs_i_gnt    = bus.i_gnt;
        obs_d_gnt    = bus.d_gnt;
        obs_ram_addr = 32'(bus.ram_addr);
        chk("i_gnt", 32'(bus.i_gnt), 32'(e_i));
        chk("d_gnt", 32'(bus.d_gnt), 32'(e_d));
        chk("ram_en", 32'(bus.ram_en), 32'(e_i | e_d));
        chk("ram_wen", 32'(bus.ram_wen), e_d ? 32'(dw) : 32'h0);
        if (e_i || e_d) chk("ram_addr", 32'(bus.ram_addr), 32'(widx(e_d ? da : ia)));
        if (e_d && dw != 4'h0) chk("ram_wdata", bus.ram_wdata, dd);

        // expected returns and memory effect
        e_iv = e_i;
        e_ir = e_i ? ref_mem[widx(ia)] : 32'h0;
        e_dv = e_d && (dw == 4'h0);
        e_dr = e_dv ? ref_mem[widx(da)] : 32'h0;
        if (e_d && dw != 4'h0) begin
            wv = ref_mem[widx(da)];
            for (int b = 0; b < 4; b++) if (dw[b]) wv[8*b +: 8] = dd[8*b +: 8];
            ref_mem[widx(da)] = wv;
        end
`ifdef ARB_RR_EN
        if (ir && dr) ref_inst_next = !ref_inst_next;
`else
        if (ir && !e_i) ref_denials = (ref_denials + 1 > STARVE_MAX) ? STARVE_MAX : ref_denials + 1;
        else            ref_denials = 0;
`endif

        @(posedge clk);
        #1;
        obs_d_rvalid = bus.d_rvalid;
        obs_i_rdata  = bus.i_rdata;
        obs_d_rdata  = bus.d_rdata;
        chk("i_rvalid", 32'(bus.i_rvalid), 32'(e_iv));
        chk("i_rdata", bus.i_rdata, e_ir);
        chk("d_rvalid", 32'(bus.d_rvalid), 32'(e_dv));
        chk("d_rdata", bus.d_rdata, e_dr);
        $display("cyc i_req=%0d d_req=%0d wen=%h gnt i=%0d d=%0d rdata i=%h d=%h",
                 ir, dr, dw, obs_i_gnt, obs_d_gnt, obs_i_rdata, obs_d_rdata);
    endtask

    initial begin
        logic [9:0]  pat;
        logic [9:0]  exp_pat;
        bit          pi, pd;
        logic [31:0] pia, pda, pdd;
        logic [3:0]  pdw;

        for (int k = 0; k < 65536; k++) begin
            mem[k]     = init_val(k);
            ref_mem[k] = init_val(k);
        end
        bus.ram_rdata = '0;

        // 1: reset with both requesting
        rst = 1'b1;
        bus.i_req = 1'b1; bus.i_addr = 32'h0;
        bus.d_req = 1'b1; bus.d_wen = 4'h0; bus.d_addr = 32'h0; bus.d_wdata = '0;
        @(negedge clk);
        chk("rst_i_gnt", 32'(bus.i_gnt), 32'h0);
        chk("rst_d_gnt", 32'(bus.d_gnt), 32'h0);
        chk("rst_ram_en", 32'(bus.ram_en), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        chk("rel_i_rvalid", 32'(bus.i_rvalid), 32'h0);
        chk("rel_d_rvalid", 32'(bus.d_rvalid), 32'h0);
        do_cycle(0, 32'h0, 0, 4'h0, 32'h0, 32'h0);

        // 2: inst read alone
        do_cycle(1, 32'h10, 0, 4'h0, 32'h0, 32'h0);
        chk("t2_ram_addr", obs_ram_addr, 32'h4);
        chk("t2_i_rdata", obs_i_rdata, init_val(4));

        // 3: full write, read back, byte write, read back
        do_cycle(0, 32'h0, 1, 4'hF, 32'h20, 32'hDEADBEEF);
        chk("t3_wr_no_rvalid", 32'(obs_d_rvalid), 32'h0);
        do_cycle(0, 32'h0, 1, 4'h0, 32'h20, 32'h0);
        chk("t3_rd", obs_d_rdata, 32'hDEADBEEF);
        do_cycle(0, 32'h0, 1, 4'h1, 32'h20, 32'h000000AA);
        do_cycle(0, 32'h0, 1, 4'h0, 32'h20, 32'h0);
        chk("t3_byte_rd", obs_d_rdata, 32'hDEADBEAA);

        // 4/5: both held for ten cycles
        pat = '0;
        for (int c = 0; c < 10; c++) begin
            do_cycle(1, 32'h40, 1, 4'h0, 32'h80, 32'h0);
            pat[c] = obs_i_gnt;
        end
`ifdef ARB_RR_EN
        exp_pat = 10'b0101010101;
`else
        exp_pat = 10'b1000010000;
`endif
        chk("contention_pattern", 32'(pat), 32'(exp_pat));

        // 6: reset right after a read grant drops the return
        do_cycle(0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
        bus.i_req = 1'b1; bus.i_addr = 32'h8;
        bus.d_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("t6_i_rvalid", 32'(bus.i_rvalid), 32'h0);
        chk("t6_d_rvalid", 32'(bus.d_rvalid), 32'h0);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk("t6_hold_i_rvalid", 32'(bus.i_rvalid), 32'h0);
            chk("t6_hold_i_gnt", 32'(bus.i_gnt), 32'h0);
        end
        rst = 1'b0;
        model_reset();
        do_cycle(0, 32'h0, 0, 4'h0, 32'h0, 32'h0);

        // random traffic; requesters hold their request until granted
        pi = 0; pd = 0; pia = '0; pda = '0; pdd = '0; pdw = '0;
        for (int c = 0; c < 400; c++) begin
            if (!pi && ($urandom_range(0, 3) != 0)) begin
                pi  = 1;
                pia = $urandom & 32'hFFFC_00FF;
            end
            if (!pd && ($urandom_range(0, 3) != 0)) begin
                pd  = 1;
                pda = $urandom & 32'hFFFC_00FF;
                pdd = $urandom;
                pdw = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            end
            do_cycle(pi, pia, pd, pdw, pda, pdd);
            if (obs_i_gnt) pi = 0;
            if (obs_d_gnt) pd = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
